// File: rtl/tin_pulse_gen.sv
// Button front end for t_ff: synchronises and debounces a raw button level and
// emits single-cycle toggle pulses on tin, with optional auto-repeat while held.
module tin_pulse_gen #(
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int HOLD_CYCLES     = 50000,
    parameter int REPEAT_CYCLES   = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    input  logic enable,
    input  logic rpt_en,
    output logic tin,
    output logic btn_level,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        REPEAT,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic             s1, s2;
    logic             pulse, level_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_in;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            tin       <= 1'b0;
            btn_level <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            tin       <= pulse & enable;
            btn_level <= level_n;
        end
    end

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    // A pulse due while tin is still high is held off one cycle, so tin can
    // never be high on two consecutive cycles even with one-cycle periods.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pulse   = 1'b0;
        level_n = btn_level;
        case (state)
            IDLE: begin
                level_n = 1'b0;
                cnt_n   = '0;
                if (s2) state_n = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!s2) begin
                    state_n = IDLE;
                end else if (cnt == DEB_LAST) begin
                    state_n = PRESSED;
                    level_n = 1'b1;
                    pulse   = 1'b1;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            PRESSED: begin
                if (!s2) begin
                    state_n = RELEASE_WAIT;
                end else if (!rpt_en) begin
                    cnt_n = '0;
                end else if (cnt == HOLD_LAST) begin
                    if (!tin) begin
                        pulse   = 1'b1;
                        state_n = REPEAT;
                    end
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            REPEAT: begin
                if (!s2) begin
                    state_n = RELEASE_WAIT;
                end else if (!rpt_en) begin
                    state_n = PRESSED;
                end else if (cnt == REP_LAST) begin
                    if (!tin) begin
                        pulse = 1'b1;
                        cnt_n = '0;
                    end
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            RELEASE_WAIT: begin
                if (s2) begin
                    state_n = PRESSED;
                end else if (cnt == DEB_LAST) begin
                    state_n = IDLE;
                    level_n = 1'b0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: state_n = IDLE;
        endcase
        if (state_n != state) cnt_n = '0;
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_tin_pulse_gen.sv
// Directed bench for tin_pulse_gen with short debounce/hold/repeat periods;
// expected edge timings and pulse counts are worked out by hand.
module tb_tin_pulse_gen;

    logic clk, rst, btnIn, enable, rptEn;
    logic tin, btnLevel, busy;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;
    int pulses     = 0;
    int adjacent   = 0;
    logic prevTin  = 1'b0;
    int p0, a0;

    tin_pulse_gen #(
        .CNT_W(16),
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(10),
        .REPEAT_CYCLES(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btnIn),
        .enable(enable),
        .rpt_en(rptEn),
        .tin(tin),
        .btn_level(btnLevel),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor: counts tin pulses and back-to-back highs, sampled mid-cycle.
    always @(negedge clk) begin
        if (tin === 1'b1) pulses++;
        if (tin === 1'b1 && prevTin === 1'b1) adjacent++;
        prevTin = tin;
    end

    task automatic applyStimulus(input logic btn, input int cycles);
        btnIn = btn;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; btnIn = 1'b1; enable = 1'b1; rptEn = 1'b0;

        // Reset held with button pressed, then release reset
        #3;
        checkOutput("rst_tin", tin, 1'b0);
        checkOutput("rst_level", btnLevel, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        applyStimulus(1, 2);
        checkOutput("rst_hold_busy", busy, 1'b0);
        rst = 1'b1;
        p0 = pulses; a0 = adjacent;
        applyStimulus(1, 6);
        checkOutput("t1_tin_early", tin, 1'b0);
        applyStimulus(1, 1);
        checkOutput("t1_tin_edge6", tin, 1'b1);
        checkOutput("t1_level", btnLevel, 1'b1);
        checkOutput("t1_busy", busy, 1'b1);
        applyStimulus(1, 1);
        checkOutput("t1_tin_single", tin, 1'b0);
        applyStimulus(1, 38);
        applyStimulus(0, 6);
        checkOutput("t1_level_hold", btnLevel, 1'b1);
        applyStimulus(0, 1);
        checkOutput("t1_level_fall", btnLevel, 1'b0);
        checkOutput("t1_busy_idle", busy, 1'b0);
        checkOutput("t1_pulses", pulses - p0, 1);

        // Clean press, no repeat
        $display("[TB] clean press");
        p0 = pulses;
        applyStimulus(1, 6);
        checkOutput("t2_tin_early", tin, 1'b0);
        applyStimulus(1, 1);
        checkOutput("t2_tin", tin, 1'b1);
        applyStimulus(1, 33);
        applyStimulus(0, 6);
        checkOutput("t2_level_hold", btnLevel, 1'b1);
        applyStimulus(0, 1);
        checkOutput("t2_level_fall", btnLevel, 1'b0);
        checkOutput("t2_pulses", pulses - p0, 1);

        // Press bounce then release bounce
        $display("[TB] bounce");
        p0 = pulses;
        applyStimulus(1, 1);
        applyStimulus(0, 1);
        applyStimulus(1, 1);
        applyStimulus(0, 1);
        applyStimulus(1, 6);
        checkOutput("t3_tin_early", tin, 1'b0);
        checkOutput("t3_no_bounce_pulse", pulses - p0, 0);
        applyStimulus(1, 1);
        checkOutput("t3_tin", tin, 1'b1);
        applyStimulus(1, 5);
        applyStimulus(0, 1);
        applyStimulus(1, 1);
        applyStimulus(0, 10);
        checkOutput("t3_level", btnLevel, 1'b0);
        checkOutput("t3_busy", busy, 1'b0);
        checkOutput("t3_pulses", pulses - p0, 1);

        // Short glitch is rejected
        $display("[TB] glitch");
        p0 = pulses;
        applyStimulus(1, 3);
        checkOutput("t4_busy_mid", busy, 1'b1);
        checkOutput("t4_level_mid", btnLevel, 1'b0);
        applyStimulus(0, 10);
        checkOutput("t4_pulses", pulses - p0, 0);
        checkOutput("t4_level", btnLevel, 1'b0);
        checkOutput("t4_busy", busy, 1'b0);

        // Auto-repeat: pulses after edges 6,16,21,26,31,36,41
        $display("[TB] auto-repeat");
        rptEn = 1'b1;
        p0 = pulses; a0 = adjacent;
        applyStimulus(1, 7);
        checkOutput("t5_press", tin, 1'b1);
        applyStimulus(1, 10);
        checkOutput("t5_first_rpt", tin, 1'b1);
        applyStimulus(1, 4);
        checkOutput("t5_gap", tin, 1'b0);
        applyStimulus(1, 1);
        checkOutput("t5_second_rpt", tin, 1'b1);
        applyStimulus(1, 18);
        applyStimulus(0, 1);
        checkOutput("t5_e40", tin, 1'b0);
        applyStimulus(0, 1);
        checkOutput("t5_last_rpt", tin, 1'b1);
        applyStimulus(0, 10);
        checkOutput("t5_pulses", pulses - p0, 7);
        checkOutput("t5_adjacent", adjacent - a0, 0);
        checkOutput("t5_busy", busy, 1'b0);

        // Enable gating, then reset mid-REPEAT
        $display("[TB] enable gating and reset");
        enable = 1'b0;
        p0 = pulses;
        applyStimulus(1, 24);
        checkOutput("t6_suppressed", pulses - p0, 0);
        enable = 1'b1;
        applyStimulus(1, 2);
        checkOutput("t6_e25", tin, 1'b0);
        applyStimulus(1, 1);
        checkOutput("t6_rpt_after_en", tin, 1'b1);
        applyStimulus(1, 5);
        checkOutput("t6_rpt_e31", tin, 1'b1);
        rst = 1'b0;
        #1;
        checkOutput("t6_rst_tin", tin, 1'b0);
        checkOutput("t6_rst_busy", busy, 1'b0);
        checkOutput("t6_rst_level", btnLevel, 1'b0);
        applyStimulus(1, 2);
        rst = 1'b1;
        rptEn = 1'b0;
        applyStimulus(1, 6);
        checkOutput("t6_repress_early", tin, 1'b0);
        applyStimulus(1, 1);
        checkOutput("t6_repress", tin, 1'b1);
        checkOutput("t6_repress_level", btnLevel, 1'b1);
        applyStimulus(0, 10);
        checkOutput("t6_final_level", btnLevel, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
